// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
// Optional MEM_WAIT_EN: FETCH and MEM stall until mem_ack; otherwise every access is single-cycle.
module multicycle_ctrl #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   zero,
  input  logic                   mem_ack,
  output logic                   pc_write,
  output logic [1:0]             npc_sel,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic                   alu_src,
  output logic                   shamt_src,
  output logic [1:0]             data_to_reg,
  output logic [1:0]             ext_op,
  output logic [2:0]             alu_op,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   illegal,
  output logic [2:0]             state,
  output logic [INSTR_CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLL, I_JR, I_ORI, I_LUI,
    I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
  } instr_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] npc_sel;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       shamt_src;
    logic [1:0] data_to_reg;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
  } ctrl_t;

  state_e                 state_q, state_d;
  logic [INSTR_CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  instr_e                 instr;
  ctrl_t                  ctrl;
  logic                   mem_done;

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ack;
`else
  logic unused_mem_ack;
  assign unused_mem_ack = mem_ack;
  assign mem_done       = 1'b1;
`endif

  always_comb begin
    instr = I_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   instr = I_ADDU;
          6'h23:   instr = I_SUBU;
          6'h00:   instr = I_SLL;
          6'h08:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      6'h0D:   instr = I_ORI;
      6'h0F:   instr = I_LUI;
      6'h23:   instr = I_LW;
      6'h2B:   instr = I_SW;
      6'h04:   instr = I_BEQ;
      6'h02:   instr = I_J;
      6'h03:   instr = I_JAL;
      default: instr = I_ILL;
    endcase
  end

  // NOTE: every output and next-state value gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;

    // ALU set-up depends only on the latched IR, so it stays stable through EXEC, MEM and WB.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (instr)
        I_SUBU, I_BEQ: ctrl.alu_op = 3'b001;
        I_SLL: begin
          ctrl.alu_op    = 3'b011;
          ctrl.shamt_src = 1'b1;
        end
        I_ORI: begin
          ctrl.alu_op  = 3'b010;
          ctrl.alu_src = 1'b1;
          ctrl.ext_op  = 2'b00;
        end
        I_LUI: begin
          ctrl.alu_src = 1'b1;
          ctrl.ext_op  = 2'b10;
        end
        I_LW, I_SW: begin
          ctrl.alu_src = 1'b1;
          ctrl.ext_op  = 2'b01;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_done) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr)
          I_J: begin
            ctrl.pc_write = 1'b1;
            ctrl.npc_sel  = 2'b10;
            state_d       = S_FETCH;
          end
          I_JAL: begin
            ctrl.pc_write    = 1'b1;
            ctrl.npc_sel     = 2'b10;
            ctrl.reg_write   = 1'b1;
            ctrl.reg_dst     = 2'b10;
            ctrl.data_to_reg = 2'b10;
            state_d          = S_FETCH;
          end
          I_JR: begin
            ctrl.pc_write = 1'b1;
            ctrl.npc_sel  = 2'b11;
            state_d       = S_FETCH;
          end
          I_ILL: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (instr == I_BEQ) begin
          ctrl.pc_write = zero;
          ctrl.npc_sel  = 2'b01;
          state_d       = S_FETCH;
        end else if (instr == I_LW || instr == I_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (instr == I_SW);
        if (mem_done) state_d = (instr == I_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        ctrl.reg_write   = 1'b1;
        ctrl.reg_dst     = (opcode == 6'h00) ? 2'b01 : 2'b00;
        ctrl.data_to_reg = (instr == I_LW) ? 2'b01 : 2'b00;
        state_d          = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Illegal exits return to FETCH without retiring anything.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (state_d == S_FETCH && state_q != S_FETCH && !ctrl.illegal)
      instr_cnt_d = instr_cnt_q + INSTR_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Strobes are gated by reset directly so an abort silences them without waiting for a clock.
  assign {pc_write, npc_sel, ir_write, reg_write, reg_dst, alu_src, shamt_src,
          data_to_reg, ext_op, alu_op, mem_req, mem_we, illegal} = reset ? '0 : ctrl;

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle state and control vectors for each instruction.
// Build with MEM_WAIT_EN defined to also exercise the memory-wait handshake.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ack;

  logic       pc_write, ir_write, reg_write, alu_src, shamt_src, mem_req, mem_we, illegal;
  logic [1:0] npc_sel, reg_dst, data_to_reg, ext_op;
  logic [2:0] alu_op, state;
  logic [3:0] instr_cnt;

`ifdef MEM_WAIT_EN
  initial mem_ack = 1'b1;
`else
  initial mem_ack = 1'b0;
`endif

  multicycle_ctrl #(.INSTR_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .pc_write(pc_write), .npc_sel(npc_sel), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .shamt_src(shamt_src),
    .data_to_reg(data_to_reg), .ext_op(ext_op), .alu_op(alu_op), .mem_req(mem_req),
    .mem_we(mem_we), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] npc_sel;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       shamt_src;
    logic [1:0] data_to_reg;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {pc_write, npc_sel, ir_write, reg_write, reg_dst, alu_src, shamt_src,
                data_to_reg, ext_op, alu_op, mem_req, mem_we, illegal};

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic ctrl_t c_fetch();
    ctrl_t c = '0;
    c.mem_req  = 1'b1;
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t c_alu(input logic [2:0] op, input logic src,
                                  input logic [1:0] ext, input logic sh);
    ctrl_t c = '0;
    c.alu_op    = op;
    c.alu_src   = src;
    c.ext_op    = ext;
    c.shamt_src = sh;
    return c;
  endfunction

  // Called just after a falling edge; checks mid-cycle, then advances to the next falling edge.
  task automatic cyc(input string tag, input logic [2:0] st, input ctrl_t e);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctrl"}, 32'(obs), 32'(e));
    @(negedge clk);
  endtask

  task automatic do_fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    #1;
    check({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt % 16));
    cyc({tag, "_F"}, 3'd0, c_fetch());
  endtask

  task automatic run_r(input string tag, input logic [5:0] fn, input logic [2:0] op,
                       input logic sh);
    ctrl_t e;
    do_fetch(tag, 6'h00, fn);
    cyc({tag, "_D"}, 3'd1, '0);
    e = c_alu(op, 1'b0, 2'b00, sh);
    cyc({tag, "_X"}, 3'd2, e);
    e.reg_write = 1'b1;
    e.reg_dst   = 2'b01;
    cyc({tag, "_W"}, 3'd4, e);
    exp_cnt++;
  endtask

  task automatic run_i(input string tag, input logic [5:0] opc, input logic [2:0] op,
                       input logic [1:0] ext);
    ctrl_t e;
    do_fetch(tag, opc, 6'h11);
    cyc({tag, "_D"}, 3'd1, '0);
    e = c_alu(op, 1'b1, ext, 1'b0);
    cyc({tag, "_X"}, 3'd2, e);
    e.reg_write = 1'b1;
    cyc({tag, "_W"}, 3'd4, e);
    exp_cnt++;
  endtask

  task automatic run_decode_exit(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                                 input ctrl_t e);
    do_fetch(tag, opc, fn);
    cyc({tag, "_D"}, 3'd1, e);
    if (!e.illegal) exp_cnt++;
  endtask

  ctrl_t e;

  initial begin
    // Reset state, with a jump opcode present to show outputs stay forced low.
    opcode = 6'h02;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(obs), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_r("addu", 6'h21, 3'b000, 1'b0);
    run_r("subu", 6'h23, 3'b001, 1'b0);
    run_r("sll", 6'h00, 3'b011, 1'b1);
    run_i("ori", 6'h0D, 3'b010, 2'b00);
    run_i("lui", 6'h0F, 3'b000, 2'b10);

    // lw: 0,1,2,3,4
    do_fetch("lw", 6'h23, 6'h04);
    cyc("lw_D", 3'd1, '0);
    e = c_alu(3'b000, 1'b1, 2'b01, 1'b0);
    cyc("lw_X", 3'd2, e);
    e.mem_req = 1'b1;
    cyc("lw_M", 3'd3, e);
    e.mem_req     = 1'b0;
    e.reg_write   = 1'b1;
    e.data_to_reg = 2'b01;
    cyc("lw_W", 3'd4, e);
    exp_cnt++;

    // sw: 0,1,2,3 with mem_we only in MEM
    do_fetch("sw", 6'h2B, 6'h08);
    cyc("sw_D", 3'd1, '0);
    e = c_alu(3'b000, 1'b1, 2'b01, 1'b0);
    cyc("sw_X", 3'd2, e);
    e.mem_req = 1'b1;
    e.mem_we  = 1'b1;
    cyc("sw_M", 3'd3, e);
    exp_cnt++;

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      do_fetch(z ? "beqT" : "beqN", 6'h04, 6'h00);
      cyc(z ? "beqT_D" : "beqN_D", 3'd1, '0);
      zero = z[0];
      e = c_alu(3'b001, 1'b0, 2'b00, 1'b0);
      e.pc_write = z[0];
      e.npc_sel  = 2'b01;
      cyc(z ? "beqT_X" : "beqN_X", 3'd2, e);
      zero = 1'b0;
      exp_cnt++;
    end

    e = '0; e.pc_write = 1'b1; e.npc_sel = 2'b10;
    run_decode_exit("j", 6'h02, 6'h00, e);
    e.reg_write = 1'b1; e.reg_dst = 2'b10; e.data_to_reg = 2'b10;
    run_decode_exit("jal", 6'h03, 6'h00, e);
    e = '0; e.pc_write = 1'b1; e.npc_sel = 2'b11;
    run_decode_exit("jr", 6'h00, 6'h08, e);
    e = '0; e.illegal = 1'b1;
    run_decode_exit("ill3f", 6'h3F, 6'h00, e);
    run_decode_exit("illR", 6'h00, 6'h2A, e);
    #1;
    check("ill_cnt_kept", 32'(instr_cnt), 32'(exp_cnt % 16));

`ifdef MEM_WAIT_EN
    // Fetch stalls until mem_ack, then a lw stalls in MEM and is aborted by reset.
    opcode  = 6'h23;
    funct   = 6'h00;
    mem_ack = 1'b0;
    e = '0; e.mem_req = 1'b1;
    cyc("wf0", 3'd0, e);
    cyc("wf1", 3'd0, e);
    mem_ack = 1'b1;
    cyc("wf_ack", 3'd0, c_fetch());
    cyc("w_D", 3'd1, '0);
    e = c_alu(3'b000, 1'b1, 2'b01, 1'b0);
    cyc("w_X", 3'd2, e);
    mem_ack = 1'b0;
    e.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("w_M", 3'd3, e);
    #1;
    reset = 1'b1;
    #1;
    check("w_rst_state", 32'(state), 32'd0);
    check("w_rst_ctrl", 32'(obs), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    mem_ack = 1'b1;
    exp_cnt = 0;
`endif

    // Reset mid-instruction aborts the sw before its store.
    do_fetch("sw_abort", 6'h2B, 6'h00);
    cyc("swa_D", 3'd1, '0);
    cyc("swa_X", 3'd2, c_alu(3'b000, 1'b1, 2'b01, 1'b0));
    #1;
    reset = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_ctrl", 32'(obs), 32'd0);
    check("abort_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 0;

    // Sixteen retirements wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_r("wrap", 6'h21, 3'b000, 1'b0);
    #1;
    check("wrap_cnt", 32'(instr_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
